// File: rtl/bus_term_fifo.sv
// Bus terminal endpoint: a TX FIFO feeding the shared bus (pndng/D_pop/pop) and
// an RX FIFO capturing bus deliveries (push/D_push) for the host.

module BusTermFifoCore #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wrReq_i,
  input  logic [W-1:0]            wrData_i,
  input  logic                    rdReq_i,
  output logic [W-1:0]            head_o,
  output logic                    notEmpty_o,
  output logic                    full_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    wrDrop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  logic          rdOk;
  logic          wrOk;

  // DEPTH is a power of two, so the count MSB alone marks a full FIFO.
  assign full_o     = count_q[AW];
  assign notEmpty_o = (count_q != '0);
  assign count_o    = count_q;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write.
  assign rdOk     = rdReq_i && notEmpty_o;
  assign wrOk     = wrReq_i && (!full_o || rdOk);
  assign wrDrop_o = wrReq_i && !wrOk;

  assign head_o = notEmpty_o ? mem_q[rdPtr_q] : '0;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (wrOk) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (rdOk) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({wrOk, rdOk})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; stale entries are never visible because head_o is gated.
  always_ff @(posedge clk) begin
    if (!rst && wrOk) begin
      mem_q[wrPtr_q] <= wrData_i;
    end
  end

endmodule

module bus_term_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [pckg_sz-1:0]      wr_data,
  output logic                    tx_full,
  output logic [$clog2(depth):0]  tx_count,
  output logic                    tx_ovf,
  output logic                    pndng,
  output logic [pckg_sz-1:0]      D_pop,
  input  logic                    pop,
  output logic                    tx_unf,
  input  logic                    push,
  input  logic [pckg_sz-1:0]      D_push,
  output logic                    rx_valid,
  output logic [pckg_sz-1:0]      rx_data,
  input  logic                    rx_rdy,
  output logic [$clog2(depth):0]  rx_count,
  output logic                    rx_ovf
);

  logic txDrop;
  logic rxDrop;
  logic rxFull;
  logic txOvf_q, txOvf_d;
  logic txUnf_q, txUnf_d;
  logic rxOvf_q, rxOvf_d;

  BusTermFifoCore #(
    .W     (pckg_sz),
    .DEPTH (depth)
  ) txFifo (
    .clk        (clk),
    .rst        (rst),
    .wrReq_i    (wr_en),
    .wrData_i   (wr_data),
    .rdReq_i    (pop),
    .head_o     (D_pop),
    .notEmpty_o (pndng),
    .full_o     (tx_full),
    .count_o    (tx_count),
    .wrDrop_o   (txDrop)
  );

  BusTermFifoCore #(
    .W     (pckg_sz),
    .DEPTH (depth)
  ) rxFifo (
    .clk        (clk),
    .rst        (rst),
    .wrReq_i    (push),
    .wrData_i   (D_push),
    .rdReq_i    (rx_rdy),
    .head_o     (rx_data),
    .notEmpty_o (rx_valid),
    .full_o     (rxFull),
    .count_o    (rx_count),
    .wrDrop_o   (rxDrop)
  );

  assign tx_ovf = txOvf_q;
  assign tx_unf = txUnf_q;
  assign rx_ovf = rxOvf_q;

  // Error flags accumulate until reset; a pop with nothing pending is an underflow.
  always_comb begin
    txOvf_d = txOvf_q | txDrop;
    txUnf_d = txUnf_q | (pop && !pndng);
    rxOvf_d = rxOvf_q | rxDrop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txOvf_q <= 1'b0;
      txUnf_q <= 1'b0;
      rxOvf_q <= 1'b0;
    end else begin
      txOvf_q <= txOvf_d;
      txUnf_q <= txUnf_d;
      rxOvf_q <= rxOvf_d;
    end
  end

  logic unusedRxFull;
  assign unusedRxFull = rxFull;

endmodule

// File: tb/tb_bus_term_fifo.sv
// Self-checking bench for bus_term_fifo: queue-based reference model compared
// every cycle, plus directed scenarios with literal expected values.

module tb_bus_term_fifo;

  localparam int W = 16;
  localparam int D = 8;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          tx_full;
  logic [3:0]    tx_count;
  logic          tx_ovf;
  logic          pndng;
  logic [W-1:0]  D_pop;
  logic          pop;
  logic          tx_unf;
  logic          push;
  logic [W-1:0]  D_push;
  logic          rx_valid;
  logic [W-1:0]  rx_data;
  logic          rx_rdy;
  logic [3:0]    rx_count;
  logic          rx_ovf;

  int numChecks = 0;
  int numErrors = 0;
  bit checkEn   = 0;

  logic [W-1:0] txQ[$];
  logic [W-1:0] rxQ[$];
  bit mTxOvf, mTxUnf, mRxOvf;

  bus_term_fifo #(.pckg_sz(W), .depth(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx_full  (tx_full),
    .tx_count (tx_count),
    .tx_ovf   (tx_ovf),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .tx_unf   (tx_unf),
    .push     (push),
    .D_push   (D_push),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .rx_count (rx_count),
    .rx_ovf   (rx_ovf)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numErrors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packages live in queues, flags follow the event rules directly
  always @(posedge clk) begin
    bit txPopOk, rxAccOk;
    if (rst) begin
      txQ.delete();
      rxQ.delete();
      mTxOvf = 0;
      mTxUnf = 0;
      mRxOvf = 0;
    end else begin
      txPopOk = pop && (txQ.size() > 0);
      if (pop && txQ.size() == 0) mTxUnf = 1;
      if (txPopOk) void'(txQ.pop_front());
      if (wr_en) begin
        if (txQ.size() < D) txQ.push_back(wr_data);
        else mTxOvf = 1;
      end
      rxAccOk = rx_rdy && (rxQ.size() > 0);
      if (rxAccOk) void'(rxQ.pop_front());
      if (push) begin
        if (rxQ.size() < D) rxQ.push_back(D_push);
        else mRxOvf = 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("pndng",    {31'b0, pndng},    {31'b0, txQ.size() != 0});
      checkOutput("D_pop",    {16'b0, D_pop},    (txQ.size() != 0) ? {16'b0, txQ[0]} : 32'd0);
      checkOutput("tx_count", {28'b0, tx_count}, 32'(txQ.size()));
      checkOutput("tx_full",  {31'b0, tx_full},  {31'b0, txQ.size() == D});
      checkOutput("tx_ovf",   {31'b0, tx_ovf},   {31'b0, mTxOvf});
      checkOutput("tx_unf",   {31'b0, tx_unf},   {31'b0, mTxUnf});
      checkOutput("rx_valid", {31'b0, rx_valid}, {31'b0, rxQ.size() != 0});
      checkOutput("rx_data",  {16'b0, rx_data},  (rxQ.size() != 0) ? {16'b0, rxQ[0]} : 32'd0);
      checkOutput("rx_count", {28'b0, rx_count}, 32'(rxQ.size()));
      checkOutput("rx_ovf",   {31'b0, rx_ovf},   {31'b0, mRxOvf});
    end
  end

  task automatic applyStimulus(input logic w, input logic [W-1:0] wd, input logic p,
                               input logic ps, input logic [W-1:0] dp, input logic rd);
    wr_en   = w;
    wr_data = wd;
    pop     = p;
    push    = ps;
    D_push  = dp;
    rx_rdy  = rd;
    @(posedge clk);
    #1;
    wr_en   = 0;
    wr_data = '0;
    pop     = 0;
    push    = 0;
    D_push  = '0;
    rx_rdy  = 0;
  endtask

  task automatic resetDut();
    rst = 1;
    applyStimulus(0, '0, 0, 0, '0, 0);
    rst = 0;
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_data = '0; pop = 0; push = 0; D_push = '0; rx_rdy = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    checkEn = 1;

    checkOutput("reset pndng",    {31'b0, pndng},    32'd0);
    checkOutput("reset tx_count", {28'b0, tx_count}, 32'd0);
    checkOutput("reset rx_valid", {31'b0, rx_valid}, 32'd0);
    checkOutput("reset D_pop",    {16'b0, D_pop},    32'd0);

    // Single write then pop
    applyStimulus(1, 16'hA5A5, 0, 0, '0, 0);
    checkOutput("wr pndng",    {31'b0, pndng},    32'd1);
    checkOutput("wr D_pop",    {16'b0, D_pop},    32'h0000A5A5);
    checkOutput("wr tx_count", {28'b0, tx_count}, 32'd1);
    applyStimulus(0, '0, 1, 0, '0, 0);
    checkOutput("pop pndng", {31'b0, pndng}, 32'd0);
    checkOutput("pop D_pop", {16'b0, D_pop}, 32'd0);

    // Fill TX, overflow, drain in order
    for (int i = 1; i <= 8; i++) applyStimulus(1, 16'(i), 0, 0, '0, 0);
    applyStimulus(1, 16'h0009, 0, 0, '0, 0);
    checkOutput("ovf tx_full",  {31'b0, tx_full},  32'd1);
    checkOutput("ovf tx_ovf",   {31'b0, tx_ovf},   32'd1);
    checkOutput("ovf tx_count", {28'b0, tx_count}, 32'd8);
    for (int i = 1; i <= 8; i++) begin
      checkOutput("drain D_pop", {16'b0, D_pop}, 32'(i));
      applyStimulus(0, '0, 1, 0, '0, 0);
    end
    checkOutput("drained pndng", {31'b0, pndng}, 32'd0);

    // Write and pop together while full
    resetDut();
    for (int i = 1; i <= 8; i++) applyStimulus(1, 16'(i), 0, 0, '0, 0);
    applyStimulus(1, 16'h00FF, 1, 0, '0, 0);
    checkOutput("full wr+pop count", {28'b0, tx_count}, 32'd8);
    checkOutput("full wr+pop ovf",   {31'b0, tx_ovf},   32'd0);
    for (int i = 2; i <= 8; i++) begin
      checkOutput("full wr+pop order", {16'b0, D_pop}, 32'(i));
      applyStimulus(0, '0, 1, 0, '0, 0);
    end
    checkOutput("full wr+pop last", {16'b0, D_pop}, 32'h000000FF);
    applyStimulus(0, '0, 1, 0, '0, 0);

    // Write and pop together while empty
    applyStimulus(1, 16'h0BEE, 1, 0, '0, 0);
    checkOutput("empty wr+pop unf",   {31'b0, tx_unf},   32'd1);
    checkOutput("empty wr+pop count", {28'b0, tx_count}, 32'd1);
    checkOutput("empty wr+pop D_pop", {16'b0, D_pop},    32'h00000BEE);
    applyStimulus(0, '0, 1, 0, '0, 0);

    // RX overflow then drain
    for (int i = 0; i <= 8; i++) applyStimulus(0, '0, 0, 1, 16'h1000 + 16'(i), 0);
    checkOutput("rx_ovf",       {31'b0, rx_ovf},   32'd1);
    checkOutput("rx full count", {28'b0, rx_count}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput("rx drain data", {16'b0, rx_data}, 32'h1000 + 32'(i));
      applyStimulus(0, '0, 0, 0, '0, 1);
    end
    checkOutput("rx drained valid", {31'b0, rx_valid}, 32'd0);
    applyStimulus(0, '0, 0, 0, '0, 1);

    // RX push accepted while full when the host accepts in the same cycle
    for (int i = 0; i < 8; i++) applyStimulus(0, '0, 0, 1, 16'h2000 + 16'(i), 0);
    applyStimulus(0, '0, 0, 1, 16'h2FFF, 1);
    checkOutput("rx full push+acc count", {28'b0, rx_count}, 32'd8);
    checkOutput("rx full push+acc head",  {16'b0, rx_data},  32'h00002001);
    for (int i = 0; i < 8; i++) applyStimulus(0, '0, 0, 0, '0, 1);
    checkOutput("rx full push+acc tail gone", {31'b0, rx_valid}, 32'd0);

    // Mixed independent traffic on both paths
    for (int i = 0; i < 40; i++) begin
      applyStimulus((i % 3) != 0, 16'h3000 + 16'(i), (i % 2) == 1,
                    (i % 4) != 3, 16'h4000 + 16'(i), (i % 3) == 1);
    end

    // Reset in the middle of traffic discards everything
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1, 16'h5000 + 16'(i), 0, 1, 16'h6000 + 16'(i), 0);
    rst = 1;
    applyStimulus(1, 16'h7777, 1, 1, 16'h3333, 1);
    rst = 0;
    checkOutput("mid-rst tx_count", {28'b0, tx_count}, 32'd0);
    checkOutput("mid-rst rx_count", {28'b0, rx_count}, 32'd0);
    checkOutput("mid-rst pndng",    {31'b0, pndng},    32'd0);
    checkOutput("mid-rst rx_valid", {31'b0, rx_valid}, 32'd0);
    checkOutput("mid-rst flags",    {29'b0, tx_ovf, tx_unf, rx_ovf}, 32'd0);
    applyStimulus(1, 16'h1234, 0, 0, '0, 0);
    checkOutput("post-rst D_pop", {16'b0, D_pop}, 32'h00001234);
    applyStimulus(0, '0, 0, 0, '0, 0);

    @(negedge clk);
    checkEn = 0;
    $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
    $finish;
  end

endmodule
